// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: decoded control word layout and ALUop encodings.
package riscv_pkg;

    typedef struct packed {
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       reg_write;
        logic       branch;
        logic       alu_src;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with stall (hold), flush (bubble) and valid tag.
// Define PERF_CNT_EN to add saturating stall/flush event counters.
module id_ex_pipe
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic            id_MemRead,
    input  logic            id_MemtoReg,
    input  logic            id_MemWrite,
    input  logic            id_RegWrite,
    input  logic            id_Branch,
    input  logic            id_ALUSrc,
    input  logic [1:0]      id_ALUop,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [2:0]      id_funct3,
    input  logic [6:0]      id_funct7,
    output logic            ex_valid,
    output logic            ex_MemRead,
    output logic            ex_MemtoReg,
    output logic            ex_MemWrite,
    output logic            ex_RegWrite,
    output logic            ex_Branch,
    output logic            ex_ALUSrc,
    output logic [1:0]      ex_ALUop,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
`ifdef PERF_CNT_EN
    output logic [6:0]      ex_funct7,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`else
    output logic [6:0]      ex_funct7
`endif
);

    if (CNT_W == 0) begin : g_cnt_w_check
        $error("CNT_W must be nonzero");
    end

    ctrl_t           ctrl_q, ctrl_d, id_ctrl;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [4:0]      rs1_q, rs1_d;
    logic [4:0]      rs2_q, rs2_d;
    logic [4:0]      rd_q, rd_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [6:0]      funct7_q, funct7_d;

    assign id_ctrl = '{
        mem_read:   id_MemRead,
        mem_to_reg: id_MemtoReg,
        mem_write:  id_MemWrite,
        reg_write:  id_RegWrite,
        branch:     id_Branch,
        alu_src:    id_ALUSrc,
        alu_op:     id_ALUop
    };

    // Flush takes priority over stall; a bubble clears the whole slot, not just controls.
    always_comb begin
        ctrl_d     = ctrl_q;
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        funct3_d   = funct3_q;
        funct7_d   = funct7_q;
        if (flush) begin
            ctrl_d     = CTRL_NOP;
            valid_d    = 1'b0;
            pc_d       = '0;
            rs1_data_d = '0;
            rs2_data_d = '0;
            imm_d      = '0;
            rs1_d      = '0;
            rs2_d      = '0;
            rd_d       = '0;
            funct3_d   = '0;
            funct7_d   = '0;
        end else if (!stall) begin
            ctrl_d     = id_ctrl;
            valid_d    = id_valid;
            pc_d       = id_pc;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            imm_d      = id_imm;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            rd_d       = id_rd;
            funct3_d   = id_funct3;
            funct7_d   = id_funct7;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q     <= CTRL_NOP;
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            funct3_q   <= '0;
            funct7_q   <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            funct3_q   <= funct3_d;
            funct7_q   <= funct7_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_MemRead  = ctrl_q.mem_read;
    assign ex_MemtoReg = ctrl_q.mem_to_reg;
    assign ex_MemWrite = ctrl_q.mem_write;
    assign ex_RegWrite = ctrl_q.reg_write;
    assign ex_Branch   = ctrl_q.branch;
    assign ex_ALUSrc   = ctrl_q.alu_src;
    assign ex_ALUop    = ctrl_q.alu_op;
    assign ex_pc       = pc_q;
    assign ex_rs1_data = rs1_data_q;
    assign ex_rs2_data = rs2_data_q;
    assign ex_imm      = imm_q;
    assign ex_rs1      = rs1_q;
    assign ex_rs2      = rs2_q;
    assign ex_rd       = rd_q;
    assign ex_funct3   = funct3_q;
    assign ex_funct7   = funct7_q;

`ifdef PERF_CNT_EN
    // A stall masked by a flush is counted as a flush only.
    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (stall & ~flush),
        .count(stall_cnt)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_flush_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (flush),
        .count(flush_cnt)
    );
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed self-checking bench for id_ex_pipe; counter checks run when PERF_CNT_EN is defined.
module tb_id_ex_pipe;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            stall = 1'b0;
    logic            flush = 1'b0;
    logic            id_valid;
    logic            id_MemRead, id_MemtoReg, id_MemWrite, id_RegWrite, id_Branch, id_ALUSrc;
    logic [1:0]      id_ALUop;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic [2:0]      id_funct3;
    logic [6:0]      id_funct7;

    logic            ex_valid;
    logic            ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_RegWrite, ex_Branch, ex_ALUSrc;
    logic [1:0]      ex_ALUop;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]      ex_rs1, ex_rs2, ex_rd;
    logic [2:0]      ex_funct3;
    logic [6:0]      ex_funct7;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

`ifdef PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
    logic [3:0]  stall_cnt4, flush_cnt4;
    logic            ex4_valid;
    logic            ex4_MemRead, ex4_MemtoReg, ex4_MemWrite, ex4_RegWrite, ex4_Branch, ex4_ALUSrc;
    logic [1:0]      ex4_ALUop;
    logic [XLEN-1:0] ex4_pc, ex4_rs1_data, ex4_rs2_data, ex4_imm;
    logic [4:0]      ex4_rs1, ex4_rs2, ex4_rd;
    logic [2:0]      ex4_funct3;
    logic [6:0]      ex4_funct7;
`endif

    always #5 clk = ~clk;

    id_ex_pipe #(
        .XLEN (XLEN),
        .CNT_W(32)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_MemRead (id_MemRead),
        .id_MemtoReg(id_MemtoReg),
        .id_MemWrite(id_MemWrite),
        .id_RegWrite(id_RegWrite),
        .id_Branch  (id_Branch),
        .id_ALUSrc  (id_ALUSrc),
        .id_ALUop   (id_ALUop),
        .id_pc      (id_pc),
        .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data),
        .id_imm     (id_imm),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_rd      (id_rd),
        .id_funct3  (id_funct3),
        .id_funct7  (id_funct7),
        .ex_valid   (ex_valid),
        .ex_MemRead (ex_MemRead),
        .ex_MemtoReg(ex_MemtoReg),
        .ex_MemWrite(ex_MemWrite),
        .ex_RegWrite(ex_RegWrite),
        .ex_Branch  (ex_Branch),
        .ex_ALUSrc  (ex_ALUSrc),
        .ex_ALUop   (ex_ALUop),
        .ex_pc      (ex_pc),
        .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data),
        .ex_imm     (ex_imm),
        .ex_rs1     (ex_rs1),
        .ex_rs2     (ex_rs2),
        .ex_rd      (ex_rd),
        .ex_funct3  (ex_funct3),
`ifdef PERF_CNT_EN
        .ex_funct7  (ex_funct7),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
`else
        .ex_funct7  (ex_funct7)
`endif
    );

`ifdef PERF_CNT_EN
    // Narrow-counter instance to reach saturation quickly.
    id_ex_pipe #(
        .XLEN (XLEN),
        .CNT_W(4)
    ) u_dut4 (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_MemRead (id_MemRead),
        .id_MemtoReg(id_MemtoReg),
        .id_MemWrite(id_MemWrite),
        .id_RegWrite(id_RegWrite),
        .id_Branch  (id_Branch),
        .id_ALUSrc  (id_ALUSrc),
        .id_ALUop   (id_ALUop),
        .id_pc      (id_pc),
        .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data),
        .id_imm     (id_imm),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_rd      (id_rd),
        .id_funct3  (id_funct3),
        .id_funct7  (id_funct7),
        .ex_valid   (ex4_valid),
        .ex_MemRead (ex4_MemRead),
        .ex_MemtoReg(ex4_MemtoReg),
        .ex_MemWrite(ex4_MemWrite),
        .ex_RegWrite(ex4_RegWrite),
        .ex_Branch  (ex4_Branch),
        .ex_ALUSrc  (ex4_ALUSrc),
        .ex_ALUop   (ex4_ALUop),
        .ex_pc      (ex4_pc),
        .ex_rs1_data(ex4_rs1_data),
        .ex_rs2_data(ex4_rs2_data),
        .ex_imm     (ex4_imm),
        .ex_rs1     (ex4_rs1),
        .ex_rs2     (ex4_rs2),
        .ex_rd      (ex4_rd),
        .ex_funct3  (ex4_funct3),
        .ex_funct7  (ex4_funct7),
        .stall_cnt  (stall_cnt4),
        .flush_cnt  (flush_cnt4)
    );
`endif

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctrl(input logic v, input logic mr, input logic m2r, input logic mw,
                            input logic rw, input logic br, input logic as, input logic [1:0] op);
        id_valid    = v;
        id_MemRead  = mr;
        id_MemtoReg = m2r;
        id_MemWrite = mw;
        id_RegWrite = rw;
        id_Branch   = br;
        id_ALUSrc   = as;
        id_ALUop    = op;
    endtask

    task automatic set_data(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic [2:0] f3, input logic [6:0] f7);
        id_pc       = pc;
        id_rs1_data = a;
        id_rs2_data = b;
        id_imm      = imm;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_funct3   = f3;
        id_funct7   = f7;
    endtask

    task automatic check_all_zero(input string tag);
        logic [63:0] ctrl_bits;
        ctrl_bits = {55'd0, ex_valid, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_RegWrite,
                     ex_Branch, ex_ALUSrc, ex_ALUop};
        check_eq({tag, "_ctrl"}, ctrl_bits, 64'd0);
        check_eq({tag, "_pc"}, {32'd0, ex_pc}, 64'd0);
        check_eq({tag, "_ops"}, {ex_rs1_data, ex_rs2_data}, 64'd0);
        check_eq({tag, "_imm"}, {32'd0, ex_imm}, 64'd0);
        check_eq({tag, "_fields"}, {34'd0, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7}, 64'd0);
    endtask

    initial begin
        // Everything nonzero while reset rises, before any clock edge.
        set_ctrl(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10);
        set_data(32'h40, 32'h1111, 32'h2222, 32'h3333, 5'd1, 5'd2, 5'd3, 3'd4, 7'd5);
        #1 reset = 1'b1;
        #1;
        check_all_zero("reset_async");
        step();
        check_all_zero("reset_held");
        reset = 1'b0;
        step();
        check_eq("first_load_pc", {32'd0, ex_pc}, 64'h40);
        check_eq("first_load_rw", {63'd0, ex_RegWrite}, 64'd1);
        check_eq("first_load_op", {62'd0, ex_ALUop}, 64'd2);
        check_eq("first_load_f", {44'd0, ex_rs1, ex_rs2, ex_rd, ex_funct3}, {44'd0, 5'd1, 5'd2, 5'd3, 3'd4});

        // lw x5, -4(x2)
        set_ctrl(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
        set_data(32'h44, 32'h1000, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 5'd2, 5'd0, 5'd5, 3'd2, 7'd0);
        step();
        check_eq("lw_ctrl", {55'd0, ex_valid, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_RegWrite,
                 ex_Branch, ex_ALUSrc, ex_ALUop}, {55'd0, 9'b1_1101_0100});
        check_eq("lw_imm", {32'd0, ex_imm}, 64'hFFFF_FFFC);
        check_eq("lw_ops", {ex_rs1_data, ex_rs2_data}, 64'h0000_1000_DEAD_BEEF);
        check_eq("lw_rd", {59'd0, ex_rd}, 64'd5);
        check_eq("lw_pc", {32'd0, ex_pc}, 64'h44);

        // add x7, x1, x2 then stall for three edges with sw waiting in decode
        set_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10);
        set_data(32'h48, 32'd10, 32'd20, 32'd0, 5'd1, 5'd2, 5'd7, 3'd0, 7'h20);
        step();
        check_eq("rtype_rd", {59'd0, ex_rd}, 64'd7);
        check_eq("rtype_f7", {57'd0, ex_funct7}, 64'h20);
        set_ctrl(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
        set_data(32'h4C, 32'h2000, 32'h55, 32'h8, 5'd8, 5'd9, 5'd0, 3'd2, 7'd0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("stall_rd_%0d", i), {59'd0, ex_rd}, 64'd7);
            check_eq($sformatf("stall_mw_%0d", i), {63'd0, ex_MemWrite}, 64'd0);
            check_eq($sformatf("stall_pc_%0d", i), {32'd0, ex_pc}, 64'h48);
        end
        stall = 1'b0;
        step();
        check_eq("sw_mw", {63'd0, ex_MemWrite}, 64'd1);
        check_eq("sw_rw", {63'd0, ex_RegWrite}, 64'd0);
        check_eq("sw_pc", {32'd0, ex_pc}, 64'h4C);
        check_eq("sw_imm", {32'd0, ex_imm}, 64'h8);

        // beq in decode with flush and stall together: flush wins
        set_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01);
        set_data(32'h50, 32'd3, 32'd3, 32'h10, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0);
        flush = 1'b1;
        stall = 1'b1;
        step();
        check_all_zero("flush_stall");
        flush = 1'b0;
        stall = 1'b0;

        // Decode-side bubble keeps its valid tag
        set_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        step();
        check_eq("dec_bubble_v", {63'd0, ex_valid}, 64'd1);
        check_eq("dec_bubble_b", {63'd0, ex_Branch}, 64'd0);

        // Invalid slot with live controls: valid is independent of the control bits
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10);
        step();
        check_eq("inv_slot_v", {63'd0, ex_valid}, 64'd0);
        check_eq("inv_slot_rw", {63'd0, ex_RegWrite}, 64'd1);

        // Async reset between edges
        set_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10);
        set_data(32'h60, 32'h7, 32'h8, 32'h0, 5'd5, 5'd6, 5'd11, 3'd7, 7'd0);
        step();
        check_eq("pre_rst_rw", {63'd0, ex_RegWrite}, 64'd1);
        stall = 1'b1;
        #2 reset = 1'b1;
        #1;
        check_eq("mid_rst_rw", {63'd0, ex_RegWrite}, 64'd0);
        check_all_zero("mid_rst");
        step();
        reset = 1'b0;
        stall = 1'b0;
        step();
        check_eq("post_rst_pc", {32'd0, ex_pc}, 64'h60);

`ifdef PERF_CNT_EN
        reset = 1'b1;
        #1;
        check_eq("cnt_rst_s", {32'd0, stall_cnt}, 64'd0);
        check_eq("cnt_rst_f", {32'd0, flush_cnt}, 64'd0);
        step();
        reset = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 5; i++) step();
        stall = 1'b0;
        flush = 1'b1;
        for (int i = 0; i < 2; i++) step();
        stall = 1'b1;
        step();
        stall = 1'b0;
        flush = 1'b0;
        step();
        check_eq("cnt_stall", {32'd0, stall_cnt}, 64'd5);
        check_eq("cnt_flush", {32'd0, flush_cnt}, 64'd3);
        check_eq("cnt4_flush", {60'd0, flush_cnt4}, 64'd3);

        reset = 1'b1;
        step();
        reset = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check_eq("cnt4_sat", {60'd0, stall_cnt4}, 64'd15);
        check_eq("cnt32_20", {32'd0, stall_cnt}, 64'd20);
        step();
        step();
        check_eq("cnt4_held", {60'd0, stall_cnt4}, 64'd15);
        stall = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
